// File: rtl/btn_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_LONG     = 2'd2
  } btn_state_e;

  function automatic int cnt_width(input int stable_cnt);
    return $clog2(stable_cnt);
  endfunction

  function automatic int hold_width(input int long_cnt);
    return $clog2(long_cnt + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, stability counter and hold FSM
// producing a debounced level plus press, release and long-press pulses.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = 2000,
  parameter int LONG_CNT   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic nRst,
  input  logic tick,
  input  logic button_in,
  output logic db_out,
  output logic press_pulse,
  output logic rel_pulse,
  output logic long_pulse
);

  localparam int CNT_W  = cnt_width(STABLE_CNT);
  localparam int HOLD_W = hold_width(LONG_CNT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_CNT);
  localparam logic              ACT_LOW   = (ACTIVE_LOW != 0);

  logic [1:0]        sync_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              db_q, db_d;
  logic [HOLD_W-1:0] hold_q;
  btn_state_e        state_q;
  logic              press_q, rel_q, long_q;
  logic              lvl;
  logic              acc_press, acc_rel;

  assign lvl = sync_q[1] ^ ACT_LOW;

  // NOTE: always_comb assigns every output a default first, so no latch can form.
  always_comb begin
    cnt_d     = cnt_q;
    db_d      = db_q;
    acc_press = 1'b0;
    acc_rel   = 1'b0;
    if (lvl == db_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d     = '0;
        db_d      = lvl;
        acc_press = lvl;
        acc_rel   = ~lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      sync_q  <= {2{ACT_LOW}};
      cnt_q   <= '0;
      db_q    <= 1'b0;
      hold_q  <= '0;
      state_q <= ST_RELEASED;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button_in};
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      press_q <= acc_press;
      rel_q   <= acc_rel;
      long_q  <= 1'b0;
      case (state_q)
        ST_RELEASED: begin
          hold_q <= '0;
          if (acc_press) state_q <= ST_PRESSED;
        end
        ST_PRESSED: begin
          if (acc_rel) begin
            state_q <= ST_RELEASED;
            hold_q  <= '0;
          end else if (tick) begin
            if (hold_q == HOLD_LAST) begin
              hold_q  <= HOLD_SAT;
              long_q  <= 1'b1;
              state_q <= ST_LONG;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        ST_LONG: begin
          // Counter stays saturated; only a release rearms the long pulse.
          if (acc_rel) begin
            state_q <= ST_RELEASED;
            hold_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_RELEASED;
          hold_q  <= '0;
        end
      endcase
    end
  end

  assign db_out      = db_q;
  assign press_pulse = press_q;
  assign rel_pulse   = rel_q;
  assign long_pulse  = long_q;

endmodule

// File: rtl/multi_button_debounce.sv
// N-channel button conditioner; one shared tick strobe sets the debounce and
// long-press timing of every channel.
module multi_button_debounce
  import btn_pkg::*;
#(
  parameter int CH         = 4,
  parameter int STABLE_CNT = 2000,
  parameter int LONG_CNT   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          tick,
  input  logic [CH-1:0] button_in,
  output logic [CH-1:0] db_out,
  output logic [CH-1:0] press_pulse,
  output logic [CH-1:0] rel_pulse,
  output logic [CH-1:0] long_pulse
);

  for (genvar g = 0; g < CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk         (clk),
      .nRst        (nRst),
      .tick        (tick),
      .button_in   (button_in[g]),
      .db_out      (db_out[g]),
      .press_pulse (press_pulse[g]),
      .rel_pulse   (rel_pulse[g]),
      .long_pulse  (long_pulse[g])
    );
  end

endmodule

// File: tb/tb_multi_button_debounce.sv
// Bench for multi_button_debounce: 2 channels, short counts, reference model
// driven by the same pin/tick/reset stream plus directed timing checks.
module tb_multi_button_debounce;

  localparam int CH     = 2;
  localparam int STABLE = 4;
  localparam int LONG   = 16;

  logic          clk = 1'b0;
  logic          nRst;
  logic          tick;
  logic [CH-1:0] button_in;
  logic [CH-1:0] db_out, press_pulse, rel_pulse, long_pulse;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference state: raw pin history, mismatch run length and press duration.
  bit m_s1 [CH];
  bit m_s2 [CH];
  bit m_db [CH];
  bit m_pp [CH];
  bit m_rp [CH];
  bit m_lp [CH];
  int m_run  [CH];
  int m_held [CH];
  bit m_done [CH];

  multi_button_debounce #(
    .CH(CH), .STABLE_CNT(STABLE), .LONG_CNT(LONG), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .nRst(nRst), .tick(tick), .button_in(button_in),
    .db_out(db_out), .press_pulse(press_pulse),
    .rel_pulse(rel_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic [CH-1:0] pins, input logic tk, input logic rn);
    for (int c = 0; c < CH; c++) begin
      if (!rn) begin
        m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_db[c] = 1'b0;
        m_pp[c] = 1'b0; m_rp[c] = 1'b0; m_lp[c] = 1'b0;
        m_run[c] = 0; m_held[c] = 0; m_done[c] = 1'b0;
      end else begin
        bit pressed_now;
        bit was_down;
        pressed_now = ~m_s2[c];
        was_down    = m_db[c];
        m_pp[c] = 1'b0; m_rp[c] = 1'b0; m_lp[c] = 1'b0;
        if (pressed_now == m_db[c]) m_run[c] = 0;
        else if (tk) begin
          m_run[c]++;
          if (m_run[c] == STABLE) begin
            m_run[c] = 0;
            m_db[c]  = pressed_now;
            if (pressed_now) m_pp[c] = 1'b1; else m_rp[c] = 1'b1;
          end
        end
        if (m_rp[c] || !was_down) begin
          m_held[c] = 0; m_done[c] = 1'b0;
        end else if (tk && !m_done[c]) begin
          m_held[c]++;
          if (m_held[c] == LONG) begin
            m_lp[c] = 1'b1; m_done[c] = 1'b1;
          end
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = pins[c];
      end
    end
  endtask

  // One clock: inputs driven at negedge, model advanced at posedge, DUT checked at next negedge.
  task automatic step(input logic [CH-1:0] pins, input logic tk, input logic rn);
    logic [CH-1:0] e_db, e_pp, e_rp, e_lp;
    button_in = pins; tick = tk; nRst = rn;
    @(posedge clk);
    model_edge(pins, tk, rn);
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      e_db[c] = m_db[c]; e_pp[c] = m_pp[c]; e_rp[c] = m_rp[c]; e_lp[c] = m_lp[c];
    end
    checks += 4;
    if (db_out !== e_db) begin
      errors++; $display("FAIL db_out cyc=%0d got=%b want=%b", cyc, db_out, e_db);
    end
    if (press_pulse !== e_pp) begin
      errors++; $display("FAIL press_pulse cyc=%0d got=%b want=%b", cyc, press_pulse, e_pp);
    end
    if (rel_pulse !== e_rp) begin
      errors++; $display("FAIL rel_pulse cyc=%0d got=%b want=%b", cyc, rel_pulse, e_rp);
    end
    if (long_pulse !== e_lp) begin
      errors++; $display("FAIL long_pulse cyc=%0d got=%b want=%b", cyc, long_pulse, e_lp);
    end
    cyc++;
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++; $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    int events = 0;
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 1'b1, 1'b0);
      checks++;
      if ({db_out, press_pulse, rel_pulse, long_pulse} !== '0) begin
        errors++; $display("FAIL reset_outputs got=%b want=0",
                           {db_out, press_pulse, rel_pulse, long_pulse});
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(2'b11, 1'b1, 1'b1);
      if ({db_out, press_pulse, rel_pulse, long_pulse} != '0) events++;
    end
    expect_int("idle_activity", events, 0);
  endtask

  task automatic test_clean_press();
    int first = -1, width = 0;
    bit ch1_moved = 0;
    for (int i = 0; i < 12; i++) begin
      step(2'b10, 1'b1, 1'b1);
      if (press_pulse[0]) begin
        width++;
        if (first < 0) first = i;
      end
      if (db_out[1] || press_pulse[1]) ch1_moved = 1;
    end
    expect_int("clean_press_edge", first, STABLE + 1);
    expect_int("clean_press_width", width, 1);
    expect_int("clean_ch1_quiet", int'(ch1_moved), 0);
    expect_int("clean_db_level", int'(db_out[0]), 1);
    for (int i = 0; i < 10; i++) step(2'b11, 1'b1, 1'b1);
    expect_int("clean_release_db", int'(db_out[0]), 0);
  endtask

  task automatic test_bounce();
    logic [CH-1:0] pat [5] = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
    int first = -1, n = 0;
    for (int i = 0; i < 16; i++) begin
      step((i < 5) ? pat[i] : 2'b10, 1'b1, 1'b1);
      if (press_pulse[0]) begin
        n++;
        if (first < 0) first = i;
      end
    end
    expect_int("bounce_press_count", n, 1);
    expect_int("bounce_press_edge", first, 4 + STABLE + 1);
    for (int i = 0; i < 10; i++) step(2'b11, 1'b1, 1'b1);
  endtask

  task automatic test_long_press();
    int p_idx = -1, l_idx = -1, n_long = 0, n_rel = 0;
    for (int i = 0; i < 40; i++) begin
      step(2'b01, 1'b1, 1'b1);
      if (press_pulse[1] && p_idx < 0) p_idx = i;
      if (long_pulse[1]) begin
        n_long++;
        if (l_idx < 0) l_idx = i;
      end
    end
    expect_int("long_count", n_long, 1);
    expect_int("long_delay", l_idx - p_idx, LONG);
    for (int i = 0; i < 15; i++) begin
      step(2'b11, 1'b1, 1'b1);
      if (rel_pulse[1]) n_rel++;
      if (long_pulse[1]) n_long++;
    end
    expect_int("long_rel_count", n_rel, 1);
    expect_int("long_after_release", n_long, 1);
  endtask

  task automatic test_slow_tick();
    int first = -1;
    for (int i = 0; i < 24; i++) begin
      step(2'b10, (i % 4) == 0, 1'b1);
      if (db_out[0] && first < 0) first = i;
    end
    expect_int("slow_tick_db_edge", first, 4 * STABLE);
    // Short glitch back to released with tick low must clear the count.
    for (int i = 0; i < 40; i++) begin
      logic [CH-1:0] p;
      p = ((i % 12) < 6) ? 2'b11 : 2'b10;
      step(p, (i % 4) == 0, 1'b1);
    end
    for (int i = 0; i < 24; i++) step(2'b11, (i % 4) == 0, 1'b1);
    expect_int("slow_tick_release_db", int'(db_out[0]), 0);
  endtask

  task automatic test_mid_reset();
    int n_long = 0, n_rel = 0, first = -1;
    for (int i = 0; i < 30; i++) begin
      step(2'b10, 1'b1, 1'b1);
      if (long_pulse[0]) n_long++;
    end
    expect_int("mid_reached_long", n_long, 1);
    for (int i = 0; i < 2; i++) begin
      step(2'b10, 1'b1, 1'b0);
      if (rel_pulse != '0) n_rel++;
      checks++;
      if ({db_out, press_pulse, long_pulse} !== '0) begin
        errors++; $display("FAIL mid_reset_outputs got=%b want=0",
                           {db_out, press_pulse, long_pulse});
      end
    end
    for (int i = 0; i < 10; i++) begin
      step(2'b10, 1'b1, 1'b1);
      if (rel_pulse != '0) n_rel++;
      if (press_pulse[0] && first < 0) first = i;
    end
    expect_int("mid_no_rel", n_rel, 0);
    expect_int("mid_fresh_press", first, STABLE + 1);
    for (int i = 0; i < 10; i++) step(2'b11, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic [CH-1:0] p = 2'b11;
    int len [CH] = '{0, 0};
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (len[c] == 0) begin
          p[c]   = 1'($urandom_range(0, 1));
          len[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60)
                                                : $urandom_range(1, 6);
        end
        len[c]--;
      end
      step(p, $urandom_range(0, 3) != 0, !(i == 300 || i == 301));
    end
  endtask

  initial begin
    button_in = 2'b11; tick = 1'b1; nRst = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_slow_tick();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
